multicycle_main_controller: RTL and testbench

//  Multi-cycle successor to the single-cycle main decoder. A Moore FSM that sequences each
//  RV32I instruction over 3-5 cycles (fetch/decode/execute/memory/writeback) and drives the

---
 rtl/multicycle_main_controller_if.sv | 32 +++
 rtl/multicycle_main_controller.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_main_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_controller_if.sv
// Control bus between the multicycle main controller and the datapath.
// The master modport is the controller side. The slave modport is the datapath/IR side.
interface multicycle_main_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       instr_done;
  logic       trap;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_op, imm_src, reg_write, instr_done, trap, state_dbg
  );

  modport slave (
    output op, funct3, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_op, imm_src, reg_write, instr_done, trap, state_dbg
  );
endinterface

// File: rtl/multicycle_main_controller.sv
// Multicycle RV32I main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and memory, with a memory wait counter and sticky illegal-opcode trap.
// Optional feature macro: CTRL_BNE_EN (adds bne via funct3==001; default build is beq only).
module multicycle_main_controller #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 4
) (
  input logic                          clk,
  input logic                          rst,
  multicycle_main_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StIllegal  = 4'd11
  } stateT;

  typedef struct packed {
    logic       pcUpdate;
    logic       branch;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regWrite;
    logic       instrDone;
    logic       trap;
  } ctrlT;

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_WAIT);

  stateT            state, stateNext;
  logic [CNT_W-1:0] waitCnt, cntNext;
  ctrlT             ctrl;
  logic             cntDone, taken;

  // Moore output decode for a given state; cntDone marks the last cycle of a memory access.
  function automatic ctrlT decode(stateT st, logic done);
    ctrlT c;
    c = '0;
    case (st)
      StFetch: begin
        c.aluSrcB   = 2'b10;
        c.resultSrc = 2'b10;
        c.irWrite   = done;
        c.pcUpdate  = done;
      end
      StDecode: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b01;
      end
      StMemAdr: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      StMemRead: c.adrSrc = 1'b1;
      StMemWb: begin
        c.resultSrc = 2'b01;
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      StMemWrite: begin
        c.adrSrc    = 1'b1;
        c.memWrite  = done;
        c.instrDone = done;
      end
      StExecR: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = 2'b10;
      end
      StExecI: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
        c.aluOp   = 2'b10;
      end
      StJal: begin
        c.aluSrcA  = 2'b01;
        c.aluSrcB  = 2'b10;
        c.pcUpdate = 1'b1;
      end
      StAluWb: begin
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      StBeq: begin
        c.aluSrcA   = 2'b10;
        c.aluOp     = 2'b01;
        c.branch    = 1'b1;
        c.instrDone = 1'b1;
      end
      StIllegal: c.trap = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Next-state and wait-counter logic; the counter clears on every state change.
  always_comb begin
    cntDone   = (waitCnt == WaitLast);
    stateNext = state;
    cntNext   = '0;
    case (state)
      StFetch:    if (cntDone) stateNext = StDecode;  else cntNext = waitCnt + CNT_W'(1);
      StMemRead:  if (cntDone) stateNext = StMemWb;   else cntNext = waitCnt + CNT_W'(1);
      StMemWrite: if (cntDone) stateNext = StFetch;   else cntNext = waitCnt + CNT_W'(1);
      StDecode: begin
        case (bus.op)
          OpLw, OpSw: stateNext = StMemAdr;
          OpR:        stateNext = StExecR;
          OpI:        stateNext = StExecI;
          OpJal:      stateNext = StJal;
          OpBeq:      stateNext = StBeq;
          default:    stateNext = StIllegal;
        endcase
      end
      StMemAdr:  stateNext = (bus.op == OpLw) ? StMemRead : StMemWrite;
      StExecR,
      StExecI,
      StJal:     stateNext = StAluWb;
      StMemWb,
      StAluWb,
      StBeq:     stateNext = StFetch;
      StIllegal: stateNext = StIllegal;
      default:   stateNext = StFetch;
    endcase
  end

  // State, counter and registered Moore outputs (decoded from the state being entered).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StFetch;
      waitCnt <= '0;
      ctrl    <= decode(StFetch, MEM_WAIT == 0);
    end else begin
      state   <= stateNext;
      waitCnt <= cntNext;
      ctrl    <= decode(stateNext, cntNext == WaitLast);
    end
  end

`ifdef CTRL_BNE_EN
  assign taken = (bus.funct3 == 3'b001) ? ~bus.zero : bus.zero;
`else
  logic unusedFunct3;
  assign unusedFunct3 = ^bus.funct3;
  assign taken        = bus.zero;
`endif

  // Enables are gated with rst so nothing fires while reset is held, even mid-cycle.
  assign bus.pc_write   = rst & (ctrl.pcUpdate | (ctrl.branch & taken));
  assign bus.mem_write  = rst & ctrl.memWrite;
  assign bus.ir_write   = rst & ctrl.irWrite;
  assign bus.reg_write  = rst & ctrl.regWrite;
  assign bus.instr_done = rst & ctrl.instrDone;
  assign bus.trap       = rst & ctrl.trap;
  assign bus.adr_src    = ctrl.adrSrc;
  assign bus.result_src = ctrl.resultSrc;
  assign bus.alu_src_a  = ctrl.aluSrcA;
  assign bus.alu_src_b  = ctrl.aluSrcB;
  assign bus.alu_op     = ctrl.aluOp;
  assign bus.state_dbg  = state;

  // Immediate format straight from the opcode.
  always_comb begin
    bus.imm_src = 2'b00;
    case (bus.op)
      OpSw:    bus.imm_src = 2'b01;
      OpBeq:   bus.imm_src = 2'b10;
      OpJal:   bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: one DUT with MEM_WAIT=0, one with MEM_WAIT=2.
module tb_multicycle_main_controller;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst2 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_main_controller_if if0 ();
  multicycle_main_controller_if if2 ();

  multicycle_main_controller #(.MEM_WAIT(0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  multicycle_main_controller #(.MEM_WAIT(2), .CNT_W(4)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBeq = 7'b1100011;

  // Advance to the next sample point (just after the falling edge).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset0(input logic [6:0] op);
    rst0 = 1'b0;
    if0.op = op; if0.funct3 = 3'b000; if0.zero = 1'b0;
    @(negedge clk); @(negedge clk);
    rst0 = 1'b1;
    #1;
  endtask

  task automatic reset2(input logic [6:0] op);
    rst2 = 1'b0;
    if2.op = op; if2.funct3 = 3'b000; if2.zero = 1'b0;
    @(negedge clk); @(negedge clk);
    rst2 = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0;
    if0.op = OpLw; if0.funct3 = 3'b000; if0.zero = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({if0.state_dbg, if0.ir_write, if0.pc_write, if0.instr_done, if0.trap} !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b",
               {if0.state_dbg, if0.ir_write, if0.pc_write, if0.instr_done, if0.trap}, 8'h00);
    end
    @(negedge clk);
    rst0 = 1'b1;
    #1;
    checks++;
    if ({if0.ir_write, if0.pc_write, if0.alu_src_b, if0.result_src} !== 6'b11_10_10) begin
      failures++;
      $display("FAIL reset_fetch got=%b exp=111010",
               {if0.ir_write, if0.pc_write, if0.alu_src_b, if0.result_src});
    end
    step();
    #2 rst0 = 1'b0;
    #1;
    checks++;
    if (if0.state_dbg !== 4'd0) begin
      failures++;
      $display("FAIL reset_async got=%0d exp=0", if0.state_dbg);
    end
    @(negedge clk);
    rst0 = 1'b1;
  endtask

  task automatic test_lw();
    int expSt [6];
    expSt = '{0, 1, 2, 3, 4, 0};
    reset0(OpLw);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (if0.state_dbg !== 4'(expSt[i])) begin
        failures++;
        $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, if0.state_dbg, expSt[i]);
      end
      checks++;
      if ({if0.reg_write, (if0.result_src == 2'b01), if0.instr_done, if0.adr_src} !==
          {(i == 4), (i == 4), (i == 4), (i == 3)}) begin
        failures++;
        $display("FAIL lw_ctrl cyc=%0d got=%b%b%b%b", i, if0.reg_write,
                 (if0.result_src == 2'b01), if0.instr_done, if0.adr_src);
      end
      step();
    end
  endtask

  task automatic test_sw_wait();
    int expSt [9];
    expSt = '{0, 0, 0, 1, 2, 5, 5, 5, 0};
    reset2(OpSw);
    checks++;
    if (if2.imm_src !== 2'b01) begin
      failures++;
      $display("FAIL sw_imm got=%b exp=01", if2.imm_src);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (if2.state_dbg !== 4'(expSt[i])) begin
        failures++;
        $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, if2.state_dbg, expSt[i]);
      end
      checks++;
      if ({if2.ir_write, if2.pc_write, if2.mem_write, if2.instr_done} !==
          {(i == 2), (i == 2), (i == 7), (i == 7)}) begin
        failures++;
        $display("FAIL sw_ctrl cyc=%0d got=%b%b%b%b", i, if2.ir_write, if2.pc_write,
                 if2.mem_write, if2.instr_done);
      end
      step();
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3 [4];
    logic       zr [4];
    logic       expPc;
    f3 = '{3'b000, 3'b000, 3'b001, 3'b001};
    zr = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
`ifdef CTRL_BNE_EN
      expPc = (v >= 2) ? ~zr[v] : zr[v];
`else
      expPc = zr[v];
`endif
      reset0(OpBeq);
      if0.funct3 = f3[v];
      if0.zero   = zr[v];
      step();
      checks++;
      if (if0.pc_write !== 1'b0) begin
        failures++;
        $display("FAIL beq_decode_pc vec=%0d got=%b exp=0", v, if0.pc_write);
      end
      step();
      checks++;
      if ({if0.state_dbg, if0.pc_write, if0.instr_done, if0.alu_op, if0.imm_src} !==
          {4'd10, expPc, 1'b1, 2'b01, 2'b10}) begin
        failures++;
        $display("FAIL beq_exec vec=%0d got=%b exp=%b", v,
                 {if0.state_dbg, if0.pc_write, if0.instr_done, if0.alu_op, if0.imm_src},
                 {4'd10, expPc, 1'b1, 2'b01, 2'b10});
      end
      step();
      checks++;
      if (if0.state_dbg !== 4'd0) begin
        failures++;
        $display("FAIL beq_return vec=%0d got=%0d exp=0", v, if0.state_dbg);
      end
    end
    if0.zero = 1'b0; if0.funct3 = 3'b000;
  endtask

  task automatic test_jal();
    int   expSt [5];
    logic expPc [5];
    expSt = '{0, 1, 9, 8, 0};
    expPc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset0(OpJal);
    checks++;
    if (if0.imm_src !== 2'b11) begin
      failures++;
      $display("FAIL jal_imm got=%b exp=11", if0.imm_src);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({if0.state_dbg, if0.pc_write, if0.reg_write, if0.instr_done} !==
          {4'(expSt[i]), expPc[i], (i == 3), (i == 3)}) begin
        failures++;
        $display("FAIL jal_cyc cyc=%0d got=%b exp=%b", i,
                 {if0.state_dbg, if0.pc_write, if0.reg_write, if0.instr_done},
                 {4'(expSt[i]), expPc[i], (i == 3), (i == 3)});
      end
      step();
    end
  endtask

  task automatic test_alu();
    reset0(OpR);
    step(); step();
    checks++;
    if ({if0.state_dbg, if0.alu_op, if0.alu_src_a, if0.alu_src_b} !== {4'd6, 6'b10_10_00}) begin
      failures++;
      $display("FAIL rtype_exec got=%b exp=%b",
               {if0.state_dbg, if0.alu_op, if0.alu_src_a, if0.alu_src_b}, {4'd6, 6'b10_10_00});
    end
    step();
    checks++;
    if ({if0.state_dbg, if0.reg_write, if0.result_src} !== {4'd8, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL rtype_wb got=%b exp=%b", {if0.state_dbg, if0.reg_write, if0.result_src},
               {4'd8, 1'b1, 2'b00});
    end
    reset0(OpI);
    step(); step();
    checks++;
    if ({if0.state_dbg, if0.alu_op, if0.alu_src_a, if0.alu_src_b} !== {4'd7, 6'b10_10_01}) begin
      failures++;
      $display("FAIL itype_exec got=%b exp=%b",
               {if0.state_dbg, if0.alu_op, if0.alu_src_a, if0.alu_src_b}, {4'd7, 6'b10_10_01});
    end
  endtask

  task automatic test_illegal();
    reset0(7'b1111111);
    step(); step();
    for (int i = 0; i < 22; i++) begin
      checks++;
      if ({if0.state_dbg, if0.trap, if0.pc_write, if0.mem_write, if0.ir_write, if0.reg_write,
           if0.instr_done} !== {4'd11, 1'b1, 5'b00000}) begin
        failures++;
        $display("FAIL illegal_hold cyc=%0d got=%b exp=%b", i,
                 {if0.state_dbg, if0.trap, if0.pc_write, if0.mem_write, if0.ir_write,
                  if0.reg_write, if0.instr_done}, {4'd11, 1'b1, 5'b00000});
      end
      step();
    end
    #2 rst0 = 1'b0;
    #1;
    checks++;
    if ({if0.state_dbg, if0.trap} !== 5'b0) begin
      failures++;
      $display("FAIL illegal_exit got=%b exp=00000", {if0.state_dbg, if0.trap});
    end
    @(negedge clk);
    rst0 = 1'b1;
  endtask

  task automatic test_abort();
    reset2(OpSw);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (if2.state_dbg !== 4'd5) begin
      failures++;
      $display("FAIL abort_setup got=%0d exp=5", if2.state_dbg);
    end
    #2 rst2 = 1'b0;
    #1;
    checks++;
    if ({if2.state_dbg, if2.mem_write} !== 5'b0) begin
      failures++;
      $display("FAIL abort_async got=%b exp=00000", {if2.state_dbg, if2.mem_write});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({if2.state_dbg, if2.mem_write} !== 5'b0) begin
        failures++;
        $display("FAIL abort_hold cyc=%0d got=%b exp=00000", i, {if2.state_dbg, if2.mem_write});
      end
    end
    rst2 = 1'b1;
    if2.op = OpR;
  endtask

  task automatic test_back_to_back();
    int expSt [8];
    int dones;
    expSt = '{0, 1, 6, 8, 0, 1, 10, 0};
    dones = 0;
    reset0(OpR);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) if0.op = OpBeq;
      checks++;
      if (if0.state_dbg !== 4'(expSt[i])) begin
        failures++;
        $display("FAIL b2b_state cyc=%0d got=%0d exp=%0d", i, if0.state_dbg, expSt[i]);
      end
      if (if0.instr_done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=2", dones);
    end
  endtask

  initial begin
    if0.op = OpLw; if0.funct3 = 3'b000; if0.zero = 1'b0;
    if2.op = OpSw; if2.funct3 = 3'b000; if2.zero = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_jal();
    test_alu();
    test_illegal();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
